// File: rtl/bcd_conv_pkg.sv
//------------------------------------------------------------------------------
// bcd_conv_pkg
// Shared types and constants for the sequential binary-to-BCD converter.
//   state_t     : converter FSM states (IDLE, SHIFT, HOLD)
//   BCD_DIGIT_W : width of one packed BCD digit
//   min_digits  : number of decimal digits needed for the largest WIDTH-bit
//                 unsigned value; used to reject undersized DIGITS settings
//------------------------------------------------------------------------------
package bcd_conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int BCD_DIGIT_W = 4;

    // Decimal digit count of (2^width - 1). The loop bound covers any width
    // that fits a 64-bit value.
    function automatic int min_digits(input int width);
        longint unsigned v;
        int              d;
        v = (64'd1 << width) - 64'd1;
        d = 1;
        for (int k = 0; k < 20; k++) begin
            if (v >= 64'd10) begin
                v = v / 64'd10;
                d = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
//------------------------------------------------------------------------------
// bcd_add3
// Combinational double-dabble digit adjust: digits of 5 or more get +3 so the
// following left shift carries correctly into the next decimal digit.
//   i_digit : BCD digit before the shift (0..9 in normal operation)
//   o_digit : adjusted digit
// Inputs 10..15 never reach this unit; their output has no meaning.
//------------------------------------------------------------------------------
module bcd_add3
    import bcd_conv_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    assign o_digit = (i_digit >= BCD_DIGIT_W'(5)) ? (i_digit + BCD_DIGIT_W'(3)) : i_digit;

endmodule

// File: rtl/bcd_conv_seq.sv
//------------------------------------------------------------------------------
// bcd_conv_seq
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// A word is accepted in IDLE, converted over WIDTH cycles in SHIFT, and the
// registered result is presented in HOLD until the consumer takes it.
//
// Parameters
//   WIDTH  : binary input width (4..20)
//   DIGITS : BCD output digits; must cover 2^WIDTH-1
//
// Ports
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : in_bin is valid
//   in_ready  : converter can accept a word (IDLE and not in reset)
//   in_bin    : unsigned binary operand, sampled on the accept edge only
//   out_valid : out_bcd/out_blank hold a completed result (HOLD)
//   out_ready : consumer takes the result
//   out_bcd   : packed BCD result, digit 0 in bits [3:0]
//   out_blank : leading-zero flags per digit
//   busy      : conversion in progress (SHIFT)
//
// Build option
//   BCD_CONV_LZB_EN : when defined, out_blank[i] (i >= 1) flags that digit i
//                     and every higher digit are zero; out_blank[0] stays 0 so
//                     a zero result still shows "0". When undefined, out_blank
//                     is constant zero and no blanking logic exists.
//------------------------------------------------------------------------------
module bcd_conv_seq
    import bcd_conv_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_bin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
    output logic [DIGITS-1:0]             out_blank,
    output logic                          busy
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int SR_W  = BCD_W + WIDTH;
    localparam int CNT_W = $clog2(WIDTH);

    // Elaboration-time parameter checks
    generate
        if (WIDTH < 4 || WIDTH > 20) begin : g_bad_width
            $error("bcd_conv_seq: WIDTH=%0d outside 4..20", WIDTH);
        end
        if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
            $error("bcd_conv_seq: DIGITS=%0d too small for WIDTH=%0d (need %0d)",
                   DIGITS, WIDTH, min_digits(WIDTH));
        end
    endgenerate

    state_t             r_state;
    state_t             w_state_next;
    logic               w_load;
    logic               w_done;

    // {bcd, bin} working register; the binary part empties out of the top
    // into the BCD part one bit per SHIFT cycle.
    logic [SR_W-1:0]    r_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic [BCD_W-1:0]   r_out_bcd;

    logic [BCD_W-1:0]   w_adj_bcd;
    logic [SR_W-1:0]    w_shifted;
    logic [BCD_W-1:0]   w_final_bcd;

    //--------------------------------------------------------------------------
    // FSM
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_next = SHIFT;
                    w_load       = 1'b1;
                end
            end
            SHIFT: begin
                if (r_cnt == '0) begin
                    w_state_next = HOLD;
                    w_done       = 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // in_ready is gated by rst_n so it reads 0 while reset is held, even
    // though the state register already sits in IDLE.
    assign in_ready  = rst_n & (r_state == IDLE);
    assign out_valid = (r_state == HOLD);
    assign busy      = (r_state == SHIFT);

    //--------------------------------------------------------------------------
    // Digit adjust: one add-3 unit per BCD digit, applied before the shift
    //--------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_add3
            bcd_add3 u_add3 (
                .i_digit (r_shift[WIDTH + gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .o_digit (w_adj_bcd[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    // The top adjusted bit is always zero for legal DIGITS, so shifting it
    // out loses nothing.
    assign w_shifted   = {w_adj_bcd, r_shift[WIDTH-1:0]} << 1;
    assign w_final_bcd = w_shifted[SR_W-1 -: BCD_W];

    //--------------------------------------------------------------------------
    // Datapath: shift register, iteration counter, result register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_cnt     <= '0;
            r_out_bcd <= '0;
        end else begin
            if (w_load) begin
                r_shift <= {{BCD_W{1'b0}}, in_bin};
                r_cnt   <= CNT_W'(WIDTH - 1);
            end else if (r_state == SHIFT) begin
                r_shift <= w_shifted;
                if (!w_done) begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
            end
            if (w_done) begin
                r_out_bcd <= w_final_bcd;
            end
        end
    end

    assign out_bcd = r_out_bcd;

    //--------------------------------------------------------------------------
    // Leading-zero blanking
    //--------------------------------------------------------------------------
`ifdef BCD_CONV_LZB_EN
    logic [DIGITS-1:0] w_blank_next;
    logic [DIGITS-1:0] r_out_blank;
    logic              w_run_zero;

    // Walk from the most significant digit down; a digit blanks only while
    // every digit above it (and itself) is zero. Digit 0 never blanks.
    always_comb begin
        w_blank_next = '0;
        w_run_zero   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_run_zero      = w_run_zero & (w_final_bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
            w_blank_next[i] = w_run_zero;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_blank <= '0;
        end else if (w_done) begin
            r_out_blank <= w_blank_next;
        end
    end

    assign out_blank = r_out_blank;
`else
    assign out_blank = '0;
`endif

endmodule

// File: tb/tb_bcd_conv_seq.sv
//------------------------------------------------------------------------------
// tb_bcd_conv_seq
// Self-checking bench for bcd_conv_seq (WIDTH=16, DIGITS=5). Expected values
// come from a decimal reference model (repeated /10 and %10, and a
// "value < 10^i" rule for leading-zero blanking).
//------------------------------------------------------------------------------
module tb_bcd_conv_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_bin;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_bcd;
    logic [4:0]  out_blank;
    logic        busy;

    int n_checks;
    int n_fail;

    bcd_conv_seq #(.WIDTH(16), .DIGITS(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bin    (in_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_blank (out_blank),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: decimal digits by plain arithmetic
    function automatic logic [19:0] ref_bcd(input int v);
        logic [19:0] r;
        int          x;
        r = '0;
        x = v;
        for (int d = 0; d < 5; d++) begin
            r[d*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Digit i and all above it are zero exactly when v < 10^i
    function automatic logic [4:0] ref_blank(input int v);
        logic [4:0] b;
        int         p;
        b = '0;
`ifdef BCD_CONV_LZB_EN
        p = 10;
        for (int i = 1; i < 5; i++) begin
            b[i] = (v < p);
            p = p * 10;
        end
`else
        p = 0;
        if (v < p) b = '1;
`endif
        return b;
    endfunction

    // One full conversion, called and returning at a falling edge in IDLE.
    task automatic convert(input logic [15:0] v, input int stall, input bit early_ready,
                           output logic [19:0] bcd, output logic [4:0] blank,
                           output int edges, output int bcnt, output bit ok);
        bit acc;
        ok    = 1'b0;
        acc   = 1'b0;
        edges = 0;
        bcnt  = 0;
        bcd   = 'x;
        blank = 'x;
        out_ready = early_ready;
        in_bin    = v;
        in_valid  = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (in_ready) begin
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!acc) begin
            in_valid  = 1'b0;
            out_ready = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_bin   = 16'($urandom);
        for (int k = 0; k < 100; k++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            if (busy) bcnt++;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        if (!ok) begin
            out_ready = 1'b0;
            return;
        end
        repeat (stall) @(negedge clk);
        bcd       = out_bcd;
        blank     = out_blank;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        $display("conv in=%0d out_bcd=%h out_blank=%b latency=%0d", v, bcd, blank, edges);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_bin    = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid, busy, out_bcd, out_blank} !== 28'h0) begin
            n_fail++;
            $display("FAIL reset_hold: rdy=%b vld=%b busy=%b bcd=%h blank=%b required all zero",
                     in_ready, out_valid, busy, out_bcd, out_blank);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_bcd !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_release: rdy=%b vld=%b bcd=%h required rdy=1 vld=0 bcd=00000",
                     in_ready, out_valid, out_bcd);
        end
    endtask

    task automatic test_zero();
        logic [19:0] bcd;
        logic [4:0]  blank;
        int          edges, bcnt;
        bit          ok;
        convert(16'd0, 0, 1'b0, bcd, blank, edges, bcnt, ok);
        n_checks++;
        if (ok !== 1'b1 || bcd !== 20'h00000) begin
            n_fail++;
            $display("FAIL zero_value: ok=%b bcd=%h required 00000", ok, bcd);
        end
        n_checks++;
        if (edges !== 16) begin
            n_fail++;
            $display("FAIL zero_latency: got %0d edges required 16", edges);
        end
    endtask

    task automatic test_max();
        logic [19:0] bcd;
        logic [4:0]  blank;
        int          edges, bcnt;
        bit          ok;
        convert(16'd65535, 0, 1'b1, bcd, blank, edges, bcnt, ok);
        n_checks++;
        if (ok !== 1'b1 || bcd !== 20'h65535) begin
            n_fail++;
            $display("FAIL max_value: ok=%b bcd=%h required 65535", ok, bcd);
        end
        n_checks++;
        if (bcnt !== 16 || edges !== 16) begin
            n_fail++;
            $display("FAIL max_busy: busy cycles=%0d latency=%0d required 16/16", bcnt, edges);
        end
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL max_after_hs: rdy=%b vld=%b required rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic test_hold_stall();
        bit          ok;
        logic [19:0] exp;
        exp = ref_bcd(1234);
        ok  = 1'b0;
        out_ready = 1'b0;
        in_bin    = 16'd1234;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_timeout: out_valid never rose for 1234");
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_bcd !== exp || in_ready !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_stable[%0d]: vld=%b bcd=%h rdy=%b busy=%b required vld=1 bcd=%h rdy=0 busy=0",
                         i, out_valid, out_bcd, in_ready, busy, exp);
            end
            in_valid = 1'b1;
            in_bin   = 16'd7;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_bcd !== exp) begin
            n_fail++;
            $display("FAIL hold_no_accept: rdy=%b busy=%b bcd=%h required rdy=1 busy=0 bcd=%h",
                     in_ready, busy, out_bcd, exp);
        end
        $display("conv in=1234 held 5 cycles out_bcd=%h", out_bcd);
    endtask

    task automatic test_reset_mid();
        logic [19:0] bcd;
        logic [4:0]  blank;
        int          edges, bcnt;
        bit          ok;
        in_bin   = 16'd999;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_pre: busy=%b required 1", busy);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, out_valid, busy, out_bcd, out_blank} !== 28'h0) begin
            n_fail++;
            $display("FAIL midreset_outputs: rdy=%b vld=%b busy=%b bcd=%h blank=%b required all zero",
                     in_ready, out_valid, busy, out_bcd, out_blank);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        convert(16'd4095, 1, 1'b0, bcd, blank, edges, bcnt, ok);
        n_checks++;
        if (ok !== 1'b1 || bcd !== 20'h04095) begin
            n_fail++;
            $display("FAIL after_reset_value: ok=%b bcd=%h required 04095", ok, bcd);
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] res[$];
        int          acc_t[$];
        int          t;
        t = 0;
        in_bin    = 16'd10;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 100 && res.size() < 2; k++) begin
            if (in_valid && in_ready) acc_t.push_back(t);
            if (out_valid && out_ready) res.push_back(out_bcd);
            @(posedge clk);
            t++;
            @(negedge clk);
            if (acc_t.size() == 1) in_bin = 16'd59999;
            if (acc_t.size() >= 2) in_valid = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (res.size() != 2 || acc_t.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_count: results=%0d accepts=%0d required 2/2", res.size(), acc_t.size());
        end else begin
            $display("conv b2b out0=%h out1=%h spacing=%0d", res[0], res[1], acc_t[1] - acc_t[0]);
            n_checks++;
            if (res[0] !== ref_bcd(10) || res[1] !== ref_bcd(59999)) begin
                n_fail++;
                $display("FAIL b2b_values: got %h %h required %h %h",
                         res[0], res[1], ref_bcd(10), ref_bcd(59999));
            end
            n_checks++;
            if (acc_t[1] - acc_t[0] != 18) begin
                n_fail++;
                $display("FAIL b2b_spacing: got %0d cycles required 18", acc_t[1] - acc_t[0]);
            end
        end
    endtask

    task automatic test_blank();
        int          vals[3];
        logic [4:0]  exp_b[3];
        logic [19:0] bcd;
        logic [4:0]  blank;
        int          edges, bcnt;
        bit          ok;
        vals = '{1234, 0, 60000};
`ifdef BCD_CONV_LZB_EN
        exp_b = '{5'b10000, 5'b11110, 5'b00000};
`else
        exp_b = '{5'b00000, 5'b00000, 5'b00000};
`endif
        for (int i = 0; i < 3; i++) begin
            convert(16'(vals[i]), 0, 1'b0, bcd, blank, edges, bcnt, ok);
            n_checks++;
            if (ok !== 1'b1 || blank !== exp_b[i] || bcd !== ref_bcd(vals[i])) begin
                n_fail++;
                $display("FAIL blank_%0d: ok=%b blank=%b bcd=%h required blank=%b bcd=%h",
                         vals[i], ok, blank, bcd, exp_b[i], ref_bcd(vals[i]));
            end
        end
    endtask

    task automatic test_random();
        logic [19:0] bcd;
        logic [4:0]  blank;
        int          edges, bcnt;
        bit          ok;
        int          v;
        for (int i = 0; i < 12; i++) begin
            v = int'($urandom_range(0, 65535));
            if (i == 0) v = 9;
            if (i == 1) v = 10;
            convert(16'(v), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    bcd, blank, edges, bcnt, ok);
            n_checks++;
            if (ok !== 1'b1 || bcd !== ref_bcd(v) || blank !== ref_blank(v) || edges !== 16) begin
                n_fail++;
                $display("FAIL random_%0d: ok=%b bcd=%h blank=%b lat=%0d required bcd=%h blank=%b lat=16",
                         v, ok, bcd, blank, edges, ref_bcd(v), ref_blank(v));
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_zero();
        test_max();
        test_hold_stall();
        test_reset_mid();
        test_back_to_back();
        test_blank();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
